soc_system_pio_stream_buf_status: RTL

Avalon-MM slave input PIO carrying stream-buffer status from FPGA fabric to the HPS; the read-side counterpart of the stream buffer address output PIO. Synchronises a WIDTH-bit status vector, detects per-bit edges, latches them in a write-1-to-clear edge-capture register, and raises a maskable level interrupt. Sits on the lightweight HPS-to-FPGA bridge beside the buffer-address PIO; its irq goes to the HPS GIC.

---
 rtl/soc_system_pio_stream_buf_status.sv | 121 ++++++++++++
 1 files changed

// File: rtl/soc_system_pio_stream_buf_status.sv
// soc_system_pio_stream_buf_status
//
// Avalon-MM input PIO that carries stream-buffer status from the fabric to
// the HPS. in_port is synchronised, per-bit edges are latched in a
// write-1-to-clear edge-capture register, and a maskable level irq is raised.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   address     word register select (0 DATA, 1 IRQ_MASK, 2 reserved, 3 EDGE_CAPTURE)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    registered read data, bits above WIDTH read 0
//   in_port     status vector from stream logic, may be asynchronous
//   irq         level interrupt, active high
module soc_system_pio_stream_buf_status #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int unsigned ARM_COUNT = SYNC_STAGES + 1;
  localparam int unsigned ARM_W     = $clog2(ARM_COUNT + 1);
  localparam logic [ARM_W-1:0] ARM_TC = ARM_W'(ARM_COUNT);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] data_in;
  // data_in delayed by one clock; reference for edge detection
  logic [WIDTH-1:0] data_dly_q;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
  logic             armed;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en, wr_mask, wr_cap;

  assign data_in = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      32'd0:   edge_det = data_in & ~data_dly_q;
      32'd1:   edge_det = ~data_in & data_dly_q;
      default: edge_det = data_in ^ data_dly_q;
    endcase
  end

  // Edge detection stays disabled until the synchroniser and the delay flop
  // hold real samples, so a line already high at reset release is not
  // mistaken for a rising edge.
  assign armed     = (arm_cnt_q == ARM_TC);
  assign arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + 1'b1;

  assign wr_en   = chipselect & ~write_n;
  assign wr_mask = wr_en && (address == 2'd1);
  assign wr_cap  = wr_en && (address == 2'd3);

  always_comb begin
    mask_d = mask_q;
    if (wr_mask) mask_d = writedata[WIDTH-1:0];
  end

  // Clear is applied first so that a new edge in the same cycle wins.
  always_comb begin
    cap_d = cap_q;
    if (wr_cap) cap_d = cap_d & ~writedata[WIDTH-1:0];
    if (armed)  cap_d = cap_d | edge_det;
  end

  // Read mux is evaluated every cycle regardless of chipselect; reads have no side effects.
  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0:    readdata_d[WIDTH-1:0] = data_in;
      2'd1:    readdata_d[WIDTH-1:0] = mask_q;
      2'd3:    readdata_d[WIDTH-1:0] = cap_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_dly_q <= '0;
      mask_q     <= '0;
      cap_q      <= '0;
      arm_cnt_q  <= '0;
      readdata_q <= '0;
    end else begin
      data_dly_q <= data_in;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      arm_cnt_q  <= arm_cnt_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(cap_q & mask_q);

endmodule
